rom_dl_writer: RTL

ROM_DL_WRITER -- requirements
Module: rom_dl_writer

---
 rtl/rom_dl_writer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rom_dl_writer.sv
// rom_dl_writer: buffers download bytes from data_io and writes them to an SDRAM
// port through a toggle request/acknowledge handshake.
//   clk_sd      - sole clock
//   reset       - asynchronous, active-high reset
//   ioctl_*     - download bus from data_io (byte address, byte, strobe, active flag)
//   port_ack    - SDRAM acknowledge; equals port_req when the request has completed
//   port_req    - SDRAM toggle request
//   port_a/ds/d - word address, byte strobes and duplicated data of the entry in flight
//   port_we     - write enable toward SDRAM, also used to steer CPU access muxing
//   rom_loaded  - every byte of the last download has been written
//   overflow    - sticky: a byte was dropped during the current download
module rom_dl_writer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 23
) (
  input  logic          clk_sd,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          port_ack,
  output logic          port_req,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic [15:0]   port_d,
  output logic          port_we,
  output logic          rom_loaded,
  output logic          overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = AW + 1 + 8;

  typedef enum logic [1:0] {SYNC, IDLE, REQ_WAIT} state_t;

  state_t         state, state_nxt;
  logic [EW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           wr_q, downl_q, load_pend;
  logic           push_c, full_c, push_ok_c, pop_c, issue_c, pend_c;
  logic [EW-1:0]  head_c;

  // Rising edge of the write strobe during a download
  assign push_c    = ioctl_downl & ioctl_wr & ~wr_q;
  assign full_c    = (count == CW'(DEPTH));
  assign push_ok_c = push_c & ~full_c;
  assign head_c    = mem[rptr];
  assign pend_c    = load_pend | downl_q;

  // State register
  always_ff @(posedge clk_sd or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  // Next state; a pop is held off for one cycle when a dropped push coincides
  // with it so count and pointers stay frozen on the overflow cycle
  always_comb begin
    state_nxt = state;
    issue_c   = 1'b0;
    pop_c     = 1'b0;
    case (state)
      SYNC: state_nxt = IDLE;
      IDLE: begin
        if (count != '0) begin
          issue_c   = 1'b1;
          state_nxt = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        if ((port_ack == port_req) && !(push_c && full_c)) begin
          pop_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Buffer storage
  always_ff @(posedge clk_sd) begin
    if (push_ok_c) mem[wptr] <= {ioctl_addr[AW:0], ioctl_dout};
  end

  // Pointers, count, request port and status flags
  always_ff @(posedge clk_sd or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      downl_q    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      port_req   <= 1'b0;
      port_a     <= '0;
      port_ds    <= '0;
      port_d     <= '0;
      port_we    <= 1'b0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      load_pend  <= 1'b0;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;

      if (push_ok_c) wptr <= wptr + PW'(1);
      if (pop_c)     rptr <= rptr + PW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // SYNC realigns the toggle pair so a stale ack can never complete a request
      if (state == SYNC) begin
        port_req <= port_ack;
      end else if (issue_c) begin
        port_req <= ~port_req;
        port_a   <= head_c[EW-1:9];
        port_ds  <= {head_c[8], ~head_c[8]};
        port_d   <= {head_c[7:0], head_c[7:0]};
      end

      port_we <= ioctl_downl | (count != '0) | (state == REQ_WAIT);

      if (ioctl_downl && !downl_q) overflow <= 1'b0;
      if (push_c && full_c)        overflow <= 1'b1;

      // Completion waits for the falling edge of downl and a fully drained buffer
      if (ioctl_downl) begin
        rom_loaded <= 1'b0;
        load_pend  <= pend_c;
      end else if (pend_c && (count == '0) && (state == IDLE)) begin
        rom_loaded <= 1'b1;
        load_pend  <= 1'b0;
      end else begin
        load_pend  <= pend_c;
      end
    end
  end

endmodule
